// File: rtl/mul8u_dot_acc.sv
// Frame accumulator for approximate-multiplier products: sums one product per accepted
// beat, closes on in_last or MAX_LEN, and holds the result until the downstream takes it.
module mul8u_dot_acc #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256,
    localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        dbg_state
);

    // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
    // valid never waits on ready, and the result stays stable while out_valid & !out_ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_out_valid;

    logic               w_accept;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W:0]     w_sum_ext;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf_nxt;
    logic               w_close;

    assign in_ready  = (r_state != S_HOLD);
    assign w_accept  = in_valid & in_ready;

    // A new frame starts from zero, so IDLE and ACC share one adder.
    assign w_base    = (r_state == S_IDLE) ? '0 : r_acc;
    assign w_sum_ext = {1'b0, w_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign w_cnt_nxt = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_ovf_nxt = ((r_state == S_IDLE) ? 1'b0 : r_ovf) | w_sum_ext[ACC_W];
    assign w_close   = in_last | (w_cnt_nxt == CNT_W'(MAX_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_sum_ext[ACC_W-1:0];
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= w_ovf_nxt;
                        if (w_close) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_sum   = r_acc;
    assign out_cnt   = r_cnt;
    assign out_ovf   = r_ovf;
    assign out_valid = r_out_valid;
    assign dbg_state = r_state;

endmodule
